// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, interrupt
// cause codes and the synchronous exception codes it latches.
package trap_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned CAUSE_PAD  = XLEN - CODE_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTER    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RETURN   = 2'd3
  } trap_state_e;

  localparam logic [CODE_W-1:0] MEI_CODE = 5'd11;
  localparam logic [CODE_W-1:0] MSI_CODE = 5'd3;
  localparam logic [CODE_W-1:0] MTI_CODE = 5'd7;

  localparam logic [CODE_W-1:0] INST_MISALIGN  = 5'd0;
  localparam logic [CODE_W-1:0] ILLEGAL_INST   = 5'd2;
  localparam logic [CODE_W-1:0] ENV_BREAK      = 5'd3;
  localparam logic [CODE_W-1:0] LOAD_MISALIGN  = 5'd4;
  localparam logic [CODE_W-1:0] STORE_MISALIGN = 5'd6;

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Fixed-priority machine interrupt encoder: MEI > MSI > MTI.
module irq_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic              ext_irq,
  input  logic              sw_irq,
  input  logic              timer_irq,
  output logic              irq_any,
  output logic [CODE_W-1:0] irq_code
);

  always_comb begin
    irq_any  = ext_irq | sw_irq | timer_irq;
    irq_code = MTI_CODE;
    if (ext_irq) begin
      irq_code = MEI_CODE;
    end else if (sw_irq) begin
      irq_code = MSI_CODE;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, MRET and machine interrupts and drives
// the CSR-file trap pulses plus the PC redirect/stall for the core FSM.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTORED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_boundary,
  input  logic              exc_valid,
  input  logic [CODE_W-1:0] exc_code,
  input  logic              mret,
  input  logic              ext_irq,
  input  logic              sw_irq,
  input  logic              timer_irq,
  input  logic              interrupts_enabled,
  input  logic [XLEN-1:0]   trap_vector,
  input  logic [XLEN-1:0]   interrupted_pc,
  output logic              trap_start,
  output logic              trap_finish,
  output logic [XLEN-1:0]   trap_cause,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_target,
  output logic              busy
);

  trap_state_e       state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic              trap_start_q, trap_start_d;
  logic              trap_finish_q, trap_finish_d;
  logic              pc_redirect_q, pc_redirect_d;
  logic              busy_q, busy_d;
  logic              irq_any;
  logic [CODE_W-1:0] irq_code;
  logic [XLEN-1:0]   vec_base;

  irq_prio_enc u_irq_prio_enc (
    .ext_irq   (ext_irq),
    .sw_irq    (sw_irq),
    .timer_irq (timer_irq),
    .irq_any   (irq_any),
    .irq_code  (irq_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cause_q       <= '0;
      trap_start_q  <= 1'b0;
      trap_finish_q <= 1'b0;
      pc_redirect_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      trap_start_q  <= trap_start_d;
      trap_finish_q <= trap_finish_d;
      pc_redirect_q <= pc_redirect_d;
      busy_q        <= busy_d;
    end
  end

  // Events are only sampled in IDLE; exception beats MRET beats interrupt.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          cause_d = {1'b0, CAUSE_PAD'(0), exc_code};
          state_d = ST_ENTER;
        end else if (mret) begin
          state_d = ST_RETURN;
        end else if (inst_boundary && interrupts_enabled && irq_any) begin
          cause_d = {1'b1, CAUSE_PAD'(0), irq_code};
          state_d = ST_ENTER;
        end
      end
      ST_ENTER:    state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_RETURN:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Flags are decoded from the upcoming state so they are registered in step with it.
  always_comb begin
    trap_start_d  = 1'b0;
    trap_finish_d = 1'b0;
    pc_redirect_d = 1'b0;
    busy_d        = 1'b0;
    unique case (state_d)
      ST_ENTER: begin
        trap_start_d = 1'b1;
        busy_d       = 1'b1;
      end
      ST_REDIRECT: begin
        pc_redirect_d = 1'b1;
        busy_d        = 1'b1;
      end
      ST_RETURN: begin
        trap_finish_d = 1'b1;
        pc_redirect_d = 1'b1;
        busy_d        = 1'b1;
      end
      default: ;
    endcase
  end

  // Redirect target tracks live mtvec/mepc, so it is read a cycle after trap_start.
  always_comb begin
    vec_base  = trap_vector & 32'hFFFF_FFFC;
    pc_target = '0;
    unique case (state_q)
      ST_REDIRECT: begin
        if (VECTORED && (trap_vector[1:0] == 2'b01) && cause_q[XLEN-1]) begin
          pc_target = vec_base + XLEN'({cause_q[CODE_W-1:0], 2'b00});
        end else begin
          pc_target = vec_base;
        end
      end
      ST_RETURN: pc_target = interrupted_pc & 32'hFFFF_FFFC;
      default:   pc_target = '0;
    endcase
  end

  assign trap_start  = trap_start_q;
  assign trap_finish = trap_finish_q;
  assign trap_cause  = cause_q;
  assign pc_redirect = pc_redirect_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events
// compared against an arithmetic model of trap arbitration and redirect targets.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_boundary, exc_valid, mret, ext_irq, sw_irq, timer_irq, interrupts_enabled;
  logic [4:0]  exc_code;
  logic [31:0] trap_vector, interrupted_pc;
  logic        trap_start, trap_finish, pc_redirect, busy;
  logic [31:0] trap_cause, pc_target;
  logic        nv_trap_start, nv_trap_finish, nv_pc_redirect, nv_busy;
  logic [31:0] nv_trap_cause, nv_pc_target;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_cause;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst_boundary(inst_boundary), .exc_valid(exc_valid),
    .exc_code(exc_code), .mret(mret), .ext_irq(ext_irq), .sw_irq(sw_irq),
    .timer_irq(timer_irq), .interrupts_enabled(interrupts_enabled),
    .trap_vector(trap_vector), .interrupted_pc(interrupted_pc),
    .trap_start(trap_start), .trap_finish(trap_finish), .trap_cause(trap_cause),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .busy(busy)
  );

  trap_ctrl #(.VECTORED(1'b0)) dut_nv (
    .clk(clk), .rst_n(rst_n), .inst_boundary(inst_boundary), .exc_valid(exc_valid),
    .exc_code(exc_code), .mret(mret), .ext_irq(ext_irq), .sw_irq(sw_irq),
    .timer_irq(timer_irq), .interrupts_enabled(interrupts_enabled),
    .trap_vector(trap_vector), .interrupted_pc(interrupted_pc),
    .trap_start(nv_trap_start), .trap_finish(nv_trap_finish), .trap_cause(nv_trap_cause),
    .pc_redirect(nv_pc_redirect), .pc_target(nv_pc_target), .busy(nv_busy)
  );

  // Flags packed as {trap_start, trap_finish, pc_redirect, busy}.
  function automatic logic [3:0] flags();
    return {trap_start, trap_finish, pc_redirect, busy};
  endfunction

  task automatic clear_events();
    exc_valid = 1'b0; mret = 1'b0; ext_irq = 1'b0; sw_irq = 1'b0; timer_irq = 1'b0;
  endtask

  // Drive one event from IDLE (called #1 after a rising edge) and follow it to IDLE.
  task automatic do_event(input string tag, input bit e, input logic [4:0] c, input bit m,
                          input bit xi, input bit si, input bit ti, input bit ie, input bit ib,
                          input logic [31:0] tv, input logic [31:0] ipc);
    int kind;
    int code;
    logic [31:0] tgt, tgt_nv;
    kind = 0; code = 0;
    if (e) begin
      kind = 1; model_cause = {27'd0, c};
    end else if (m) begin
      kind = 2;
    end else if (ib && ie && (xi || si || ti)) begin
      kind = 3;
      code = xi ? 11 : (si ? 3 : 7);
      model_cause = 32'h8000_0000 + 32'(code);
    end
    tgt    = tv - (tv % 4);
    tgt_nv = tgt;
    if (kind == 3 && (tv % 4) == 1) tgt = tgt + 32'(code * 4);
    if (kind == 2) begin tgt = ipc - (ipc % 4); tgt_nv = tgt; end

    exc_valid = e; exc_code = c; mret = m; ext_irq = xi; sw_irq = si; timer_irq = ti;
    interrupts_enabled = ie; inst_boundary = ib; trap_vector = tv; interrupted_pc = ipc;
    @(posedge clk); #1;
    clear_events();

    total++;
    if (trap_cause !== model_cause) begin
      bad++; $display("FAIL %s cause: got %h want %h", tag, trap_cause, model_cause);
    end
    if (kind == 0) begin
      total++;
      if (flags() !== 4'b0000) begin
        bad++; $display("FAIL %s idle_flags: got %b want 0000", tag, flags());
      end
    end else if (kind == 2) begin
      total++;
      if (flags() !== 4'b0111) begin
        bad++; $display("FAIL %s ret_flags: got %b want 0111", tag, flags());
      end
      total++;
      if (pc_target !== tgt) begin
        bad++; $display("FAIL %s ret_target: got %h want %h", tag, pc_target, tgt);
      end
      @(posedge clk); #1;
      total++;
      if (flags() !== 4'b0000) begin
        bad++; $display("FAIL %s ret_done: got %b want 0000", tag, flags());
      end
    end else begin
      total++;
      if (flags() !== 4'b1001) begin
        bad++; $display("FAIL %s enter_flags: got %b want 1001", tag, flags());
      end
      @(posedge clk); #1;
      total++;
      if (flags() !== 4'b0011) begin
        bad++; $display("FAIL %s redir_flags: got %b want 0011", tag, flags());
      end
      total++;
      if (pc_target !== tgt) begin
        bad++; $display("FAIL %s target: got %h want %h", tag, pc_target, tgt);
      end
      total++;
      if (nv_pc_target !== tgt_nv) begin
        bad++; $display("FAIL %s target_nonvec: got %h want %h", tag, nv_pc_target, tgt_nv);
      end
      @(posedge clk); #1;
      total++;
      if (flags() !== 4'b0000) begin
        bad++; $display("FAIL %s trap_done: got %b want 0000", tag, flags());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_events(); exc_code = '0; inst_boundary = 1'b0;
    interrupts_enabled = 1'b0; trap_vector = '0; interrupted_pc = '0;
    model_cause = '0;
    #12;
    total++;
    if ({flags(), trap_cause, pc_target} !== 68'd0) begin
      bad++; $display("FAIL reset_outputs: got %b/%h/%h want all 0", flags(), trap_cause, pc_target);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_event("exc2", 1, 5'd2, 0, 0, 0, 0, 0, 0, 32'h100, 32'h0);
    do_event("vec_mti", 0, 5'd0, 0, 0, 0, 1, 1, 1, 32'h201, 32'h0);
    do_event("all_irq", 0, 5'd0, 0, 1, 1, 1, 1, 1, 32'h200, 32'h0);
    do_event("exc_vs_irq", 1, 5'd11, 0, 1, 1, 1, 1, 1, 32'h201, 32'h0);
    do_event("irq_mie0", 0, 5'd0, 0, 1, 0, 0, 0, 1, 32'h201, 32'h0);
    do_event("irq_nobnd", 0, 5'd0, 0, 0, 1, 0, 1, 0, 32'h201, 32'h0);
    do_event("mret", 0, 5'd0, 1, 0, 0, 0, 0, 0, 32'h201, 32'h1003);
    do_event("mret_vs_exc", 1, 5'd4, 1, 0, 0, 0, 0, 0, 32'h300, 32'h1003);
    do_event("wrap_mei", 0, 5'd0, 0, 1, 0, 0, 1, 1, 32'hFFFF_FFFD, 32'h0);
    do_event("vec_msi", 0, 5'd0, 0, 0, 1, 1, 1, 1, 32'h401, 32'h0);
  endtask

  // Exception re-raised during ENTER and REDIRECT must not produce a second trap.
  task automatic test_ignore_mid();
    int starts;
    starts = 0;
    exc_valid = 1'b1; exc_code = 5'd3; trap_vector = 32'h800;
    @(posedge clk); #1;
    exc_code = 5'd6;
    for (int i = 0; i < 6; i++) begin
      if (trap_start === 1'b1) starts++;
      if (i == 2) exc_valid = 1'b0;
      @(posedge clk); #1;
    end
    model_cause = 32'h3;
    total++;
    if (starts != 1) begin
      bad++; $display("FAIL ignore_mid starts: got %0d want 1", starts);
    end
    total++;
    if (trap_cause !== 32'h3) begin
      bad++; $display("FAIL ignore_mid cause: got %h want 00000003", trap_cause);
    end
  endtask

  task automatic test_reset_mid();
    exc_valid = 1'b1; exc_code = 5'd2; trap_vector = 32'h100;
    @(posedge clk); #1;
    clear_events();
    @(posedge clk); #1;
    total++;
    if (flags() !== 4'b0011) begin
      bad++; $display("FAIL rst_mid pre: got %b want 0011", flags());
    end
    #2 rst_n = 1'b0;
    #1;
    model_cause = '0;
    total++;
    if ({flags(), trap_cause} !== 36'd0) begin
      bad++; $display("FAIL rst_mid async: got %b/%h want 0/0", flags(), trap_cause);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_event("after_rst", 0, 5'd0, 0, 0, 0, 1, 1, 1, 32'h201, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] tv;
      tv = $urandom();
      if ($urandom_range(0, 1) == 0) tv[1:0] = 2'b01;
      if ($urandom_range(0, 7) == 0) tv[31:8] = 24'hFFFFFF;
      do_event("rand", $urandom_range(0, 3) == 0, 5'($urandom()), $urandom_range(0, 3) == 0,
               1'($urandom()), 1'($urandom()), 1'($urandom()),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, tv, $urandom());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_mid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the multicycle RV32 core; it is the initiator side of the CSR file's trap interface. It arbitrates synchronous exceptions, machine interrupts and MRET, and produces the one-cycle `trap_start`/`trap_finish` pulses and `trap_cause` consumed by the CSR file. It takes back `trap_vector`, `interrupted_pc` and `interrupts_enabled` and issues the PC redirect and stall to the core control FSM.

## Interface
- `VECTORED`, default 1: when 1, honour `trap_vector[1:0]==2'b01` vectored mode for interrupts.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_boundary` in 1: core is between instructions; interrupts are sampled only here.
- `exc_valid` in 1: exception raised by the current instruction (pulse).
- `exc_code` in 5: exception code, valid with `exc_valid`.
- `mret` in 1: MRET executing (pulse).
- `ext_irq`, `sw_irq`, `timer_irq` in 1 each: level-sensitive interrupt requests.
- `interrupts_enabled` in 1: mstatus.MIE from the CSR file.
- `trap_vector` in 32: mtvec from the CSR file.
- `interrupted_pc` in 32: mepc from the CSR file.
- `trap_start` out 1: one-cycle pulse to the CSR file (save state).
- `trap_finish` out 1: one-cycle pulse to the CSR file (restore MIE/MPIE).
- `trap_cause` out 32: mcause value, bit 31 set for interrupts.
- `pc_redirect` out 1: load `pc_target` into PC this cycle.
- `pc_target` out 32: redirect address.
- `busy` out 1: core must hold its state while high.

## Operation
FSM states:
- **IDLE**
  - Evaluated in priority order: `exc_valid` > `mret` > interrupt.
  - `exc_valid`: latch `trap_cause={1'b0,26'b0,exc_code}`, go to ENTER.
  - `mret`: go to RETURN.
  - Interrupt: requires `inst_boundary && interrupts_enabled && (ext_irq|sw_irq|timer_irq)`. Latch `trap_cause={1'b1,26'b0,code}`, go to ENTER.
  - Interrupt codes by priority: MEI=11 > MSI=3 > MTI=7.
- **ENTER**: `trap_start=1`, `busy=1`; go to REDIRECT.
- **REDIRECT**
  - `pc_redirect=1`, `busy=1`; go to IDLE.
  - `pc_target` is `{trap_vector[31:2],2'b00}`.
  - Exception: if `VECTORED`, `trap_vector[1:0]==2'b01` and `trap_cause[31]`, `pc_target` is instead `{trap_vector[31:2],2'b00} + (trap_cause[4:0]<<2)`.
  - Addition is 32-bit and wraps modulo 2^32.
- **RETURN**: `trap_finish=1`, `pc_redirect=1`, `pc_target={interrupted_pc[31:2],2'b00}`, `busy=1`; go to IDLE.
- Outside IDLE, `exc_valid`, `mret` and all irq inputs are ignored (the core is stalled). No pending state is kept: an irq that drops before it is sampled is lost.
- `trap_cause` holds its last latched value until the next trap is accepted.

## Timing
- Reset values: all outputs 0, `trap_cause=0`, `pc_target=0`, state IDLE. Reset asserted mid-sequence aborts to IDLE immediately, with no pulse completion.
- Exception/interrupt accepted at edge N:
  - `trap_start` and `busy` are high in cycle N+1.
  - `pc_redirect` is high in cycle N+2.
  - Back to IDLE at N+3, and a new trap can be accepted in that cycle.
- MRET accepted at edge N: `trap_finish`, `pc_redirect` and `busy` are high in cycle N+1; IDLE at N+2.
- REDIRECT reads `trap_vector` one cycle after `trap_start`, so a same-cycle mtvec write by software is not a hazard.
- `trap_start` and `trap_finish` are never high in the same cycle.
- All outputs are registered, except `pc_target`, which is combinational from state, latched cause and CSR inputs.

## Structure
- Shared package:
  - FSM state enum {IDLE, ENTER, REDIRECT, RETURN}.
  - Interrupt cause constants MEI_CODE=11, MSI_CODE=3, MTI_CODE=7.
  - Exception codes already defined there (ENV_BREAK, ILLEGAL_INST, the misalign codes).
- One sub-module, `irq_prio_enc`, which is combinational:
  - Inputs: three irq lines.
  - Outputs: `irq_any`, `irq_code[4:0]`.

## Test plan
- Reset with all inputs 0:
  - All outputs are 0.
  - `exc_valid=1`, `exc_code=2`, `trap_vector=0x100`: `trap_start` high 1 cycle with `trap_cause=0x00000002`, then `pc_redirect` with `pc_target=0x100`.
- Vectored interrupt:
  - Setup: `interrupts_enabled=1`, `inst_boundary=1`, `timer_irq=1`, `trap_vector=0x201`.
  - Expect `trap_cause=0x80000007` and `pc_target=0x21C`.
  - Repeat with `VECTORED=0`: expect `pc_target=0x200`.
- Simultaneous events:
  - `ext_irq=timer_irq=sw_irq=1`: expect cause `0x8000000B`.
  - Same cycle as `exc_valid` (code 11): exception wins with cause `0x0000000B`.
  - Irq with `interrupts_enabled=0` or `inst_boundary=0`: no trap.
- `mret` with `interrupted_pc=0x1003`:
  - `trap_finish`, `pc_redirect`, `busy` are high for 1 cycle with `pc_target=0x1000`.
  - No `trap_start`.
  - `mret` and `exc_valid` in the same cycle: exception path only.
- Mid-sequence:
  - `exc_valid` pulsed during ENTER/REDIRECT is ignored; exactly one `trap_start` is seen.
  - `rst_n` dropped in REDIRECT: `pc_redirect` and `busy` go 0 asynchronously, and the next accepted event restarts from IDLE timing.
- Wrap-around: `trap_vector=0xFFFFFFFD`, vectored, MEI → `pc_target=0x00000028`.
